// File: rtl/ram_buff_pkg.sv
// ram_buff_pkg: FSM encodings, byte-lane constants and the strobe mask shared by ram_stream_buffer.
package ram_buff_pkg;
  localparam int RAM_BUFF_DATA_W   = 128;
  localparam int RAM_BUFF_STRB_W   = RAM_BUFF_DATA_W / 8;
  localparam int RAM_BUFF_BIDX_W   = $clog2(RAM_BUFF_STRB_W);
  localparam int RAM_BUFF_MAX_STRB = 128;
  typedef enum logic [1:0] {
    RAM_BUFF_FSM_IDLE  = 2'd0,
    RAM_BUFF_FSM_FETCH = 2'd1,
    RAM_BUFF_FSM_DRAIN = 2'd2
  } ram_buff_fsm_e;
  // Callers truncate to their own strobe width; bits above it are don't-care.
  function automatic logic [RAM_BUFF_MAX_STRB-1:0] ram_buff_strb_mask(
    input int first_b, input int last_b, input logic use_first, input logic use_last);
    logic [RAM_BUFF_MAX_STRB-1:0] m;
    for (int i = 0; i < RAM_BUFF_MAX_STRB; i++)
      m[i] = (!use_first || i >= first_b) && (!use_last || i <= last_b);
    return m;
  endfunction
endpackage

// File: rtl/ram_buff_fifo.sv
// ram_buff_fifo: circular buffer with wrap-around pointers, occupancy count and a clear that beats push/pop.
module ram_buff_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] cnt_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  always_ff @(posedge clk)
    if (push_i && !clr_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(push_i);
      rd_q  <= rd_q + PW'(pop_i);
      cnt_q <= cnt_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  assign dout_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/ram_stream_buffer.sv
// ram_stream_buffer: credit-limited SRAM row reader streaming strobed rows to the MXU.
// Define RAM_STREAM_BUFFER_PERF_EN to add the stall/starve performance counters.
module ram_stream_buffer
  import ram_buff_pkg::*;
#(
  parameter int DATA_W  = RAM_BUFF_DATA_W,
  parameter int AW      = 8,
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 5,
  parameter int RAM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_vld,
  output logic                        cmd_rdy,
  input  logic [AW-1:0]               cmd_start_addr,
  input  logic [LEN_W-1:0]            cmd_len,
  input  logic [AW-1:0]               cmd_stride,
  input  logic [$clog2(DATA_W/8)-1:0] cmd_start_byte,
  input  logic [$clog2(DATA_W/8)-1:0] cmd_end_byte,
  input  logic                        flush,
  output logic                        ram_rd_vld,
  output logic [AW-1:0]               ram_rd_addr,
  input  logic [DATA_W-1:0]           ram_rd_data,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [DATA_W-1:0]           out_data,
  output logic [DATA_W/8-1:0]         out_strb,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
`ifdef RAM_STREAM_BUFFER_PERF_EN
  ,
  output logic [15:0]                 perf_stall_cnt,
  output logic [15:0]                 perf_starve_cnt
`endif
);
  localparam int SW = DATA_W / 8;
  localparam int BW = $clog2(SW);
  localparam int FW = DATA_W + SW + 1;
  localparam int CW = $clog2(DEPTH) + 2;
  ram_buff_fsm_e          state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d, stride_q, stride_d;
  logic [LEN_W-1:0]       len_q, len_d, issued_q, issued_d, pushed_q, pushed_d;
  logic [BW-1:0]          sbyte_q, sbyte_d, ebyte_q, ebyte_d;
  logic [RAM_LAT-1:0]     pipe_q, pipe_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic [FW-1:0]          fifo_dout;
  logic [SW-1:0]          strb;
  logic                   accept, pop, ret, empty;
  assign cmd_rdy     = (state_q == RAM_BUFF_FSM_IDLE) && !flush;
  assign accept      = cmd_vld && cmd_rdy;
  assign pop         = out_vld && out_rdy && !flush;
  assign ret         = pipe_q[RAM_LAT-1];
  // Credit covers buffered rows plus reads still in the RAM pipe; a same-cycle pop frees a slot.
  assign ram_rd_vld  = (state_q == RAM_BUFF_FSM_FETCH) &&
                       (CW'(fifo_cnt) + inflight_q < CW'(DEPTH) + CW'(pop));
  assign ram_rd_addr = addr_q;
  assign busy        = state_q != RAM_BUFF_FSM_IDLE;
  assign done        = pop && out_last;
  assign strb        = SW'(ram_buff_strb_mask(int'(sbyte_q), int'(ebyte_q),
                                              pushed_q == '0, pushed_q == len_q));
  always_comb begin
    state_d    = flush ? RAM_BUFF_FSM_IDLE :
                 accept ? RAM_BUFF_FSM_FETCH :
                 (state_q == RAM_BUFF_FSM_FETCH && ram_rd_vld && issued_q == len_q) ? RAM_BUFF_FSM_DRAIN :
                 (state_q == RAM_BUFF_FSM_DRAIN && done) ? RAM_BUFF_FSM_IDLE : state_q;
    len_d      = accept ? cmd_len : len_q;
    stride_d   = accept ? cmd_stride : stride_q;
    sbyte_d    = accept ? cmd_start_byte : sbyte_q;
    ebyte_d    = accept ? cmd_end_byte : ebyte_q;
    addr_d     = accept ? cmd_start_addr : ram_rd_vld ? addr_q + stride_q : addr_q;
    issued_d   = (flush || accept) ? '0 : issued_q + LEN_W'(ram_rd_vld);
    pushed_d   = (flush || accept) ? '0 : pushed_q + LEN_W'(ret);
    pipe_d     = flush ? '0 : RAM_LAT'({pipe_q, ram_rd_vld});
    inflight_d = flush ? '0 : inflight_q + CW'(ram_rd_vld) - CW'(ret);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= RAM_BUFF_FSM_IDLE;
      len_q      <= '0;
      stride_q   <= '0;
      sbyte_q    <= '0;
      ebyte_q    <= '0;
      addr_q     <= '0;
      issued_q   <= '0;
      pushed_q   <= '0;
      pipe_q     <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      stride_q   <= stride_d;
      sbyte_q    <= sbyte_d;
      ebyte_q    <= ebyte_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      pushed_q   <= pushed_d;
      pipe_q     <= pipe_d;
      inflight_q <= inflight_d;
    end
  ram_buff_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .push_i  (ret),
    .pop_i   (pop),
    .din_i   ({pushed_q == len_q, strb, ram_rd_data}),
    .dout_o  (fifo_dout),
    .cnt_o   (fifo_cnt),
    .empty_o (empty)
  );
  assign out_vld  = !empty;
  assign out_data = fifo_dout[DATA_W-1:0];
  assign out_strb = out_vld ? fifo_dout[DATA_W +: SW] : '0;
  assign out_last = out_vld && fifo_dout[FW-1];
`ifdef RAM_STREAM_BUFFER_PERF_EN
  logic [15:0] stall_q, starve_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else if (accept) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      if (busy && out_vld && !out_rdy && !(&stall_q)) stall_q <= stall_q + 16'd1;
      if (busy && !out_vld && !done && !(&starve_q)) starve_q <= starve_q + 16'd1;
    end
  assign perf_stall_cnt  = stall_q;
  assign perf_starve_cnt = starve_q;
`endif
endmodule

// File: tb/tb_ram_stream_buffer.sv
// tb_ram_stream_buffer: scoreboard bench for ram_stream_buffer with DEPTH=4, RAM_LAT=3.
module tb_ram_stream_buffer;
  import ram_buff_pkg::*;
  localparam int DATA_W = 128, AW = 8, DEPTH = 4, LEN_W = 5, RAM_LAT = 3, SW = DATA_W / 8;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SW-1:0]     strb;
    logic              last;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_vld, cmd_rdy, flush, ram_rd_vld, out_vld, out_rdy, out_last, busy, done;
  logic [AW-1:0] cmd_start_addr, cmd_stride, ram_rd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [RAM_BUFF_BIDX_W-1:0] cmd_start_byte, cmd_end_byte;
  logic [DATA_W-1:0] ram_rd_data, out_data;
  logic [SW-1:0] out_strb;
  beat_t exp_q[$];
  logic [AW-1:0] addr_exp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, last_done_cyc = -1;
  beat_t mon_b;
  logic [AW-1:0] mon_a;
  logic [AW-1:0] ram_pipe [RAM_LAT];

  ram_stream_buffer #(.DATA_W(DATA_W), .AW(AW), .DEPTH(DEPTH), .LEN_W(LEN_W), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_start_addr(cmd_start_addr), .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .cmd_start_byte(cmd_start_byte), .cmd_end_byte(cmd_end_byte), .flush(flush),
    .ram_rd_vld(ram_rd_vld), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_strb(out_strb),
    .out_last(out_last), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] row_data(input logic [AW-1:0] a);
    return {4{a, a ^ 8'hC3, a + 8'd1, ~a}};
  endfunction

  // Fixed-latency RAM: data for the address presented in cycle C appears in cycle C+RAM_LAT.
  always @(posedge clk) begin
    ram_pipe[0] <= ram_rd_addr;
    for (int i = 1; i < RAM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_rd_data = row_data(ram_pipe[RAM_LAT-1]);

  function automatic logic [SW-1:0] exp_strb(input int k, input int len, input int sb, input int eb);
    int lo = (k == 0) ? sb : 0;
    int hi = (k == len) ? eb : SW - 1;
    logic [SW-1:0] ones = '1;
    return (ones << lo) & (ones >> (SW - 1 - hi));
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_rd_vld) begin
        n_chk++;
        if (addr_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_addr: unexpected read of %h, no read required", ram_rd_addr);
        end else begin
          mon_a = addr_exp_q.pop_front();
          if (ram_rd_addr !== mon_a) begin
            n_fail++;
            $display("FAIL rd_addr: got %h, required %h", ram_rd_addr, mon_a);
          end
        end
      end
      if (out_vld && out_rdy) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat: unexpected beat data=%h, no beat required", out_data);
        end else begin
          mon_b = exp_q.pop_front();
          if (out_data !== mon_b.data || out_strb !== mon_b.strb || out_last !== mon_b.last || done !== mon_b.last) begin
            n_fail++;
            $display("FAIL beat: got data=%h strb=%h last=%b done=%b, required data=%h strb=%h last=%b done=%b",
                     out_data, out_strb, out_last, done, mon_b.data, mon_b.strb, mon_b.last, mon_b.last);
          end
        end
      end
      if (done) last_done_cyc = cyc;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] sa, input int len, input logic [AW-1:0] st,
                          input int sb, input int eb, output int t_acc);
    logic [AW-1:0] a = sa;
    beat_t b;
    for (int k = 0; k <= len; k++) begin
      addr_exp_q.push_back(a);
      b.data = row_data(a);
      b.strb = exp_strb(k, len, sb, eb);
      b.last = (k == len);
      exp_q.push_back(b);
      a = a + st;
    end
    t_acc = -1;
    sync();
    cmd_vld = 1'b1;
    cmd_start_addr = sa;
    cmd_len = LEN_W'(len);
    cmd_stride = st;
    cmd_start_byte = RAM_BUFF_BIDX_W'(sb);
    cmd_end_byte = RAM_BUFF_BIDX_W'(eb);
    for (int i = 0; i < 200 && t_acc < 0; i++) begin
      @(negedge clk);
      if (cmd_rdy) t_acc = cyc;
    end
    n_chk++;
    if (t_acc < 0) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_rdy=0 for 200 cycles, required 1");
    end
    sync();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (i < 300 && (busy || exp_q.size() != 0)) begin
      @(negedge clk);
      i++;
    end
    n_chk++;
    if (i >= 300) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b pending=%0d after 300 cycles, required idle", busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    cmd_vld = 0; flush = 0; out_rdy = 0; cmd_start_addr = '0; cmd_len = '0;
    cmd_stride = '0; cmd_start_byte = '0; cmd_end_byte = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (cmd_rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: cmd_rdy=%b busy=%b done=%b, required 1 0 0", cmd_rdy, busy, done);
    end
    n_chk++;
    if (out_vld !== 1'b0 || out_last !== 1'b0 || out_strb !== '0) begin
      n_fail++;
      $display("FAIL reset_out: out_vld=%b out_last=%b out_strb=%h, required 0 0 0", out_vld, out_last, out_strb);
    end
    n_chk++;
    if (ram_rd_vld !== 1'b0 || ram_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_ram: ram_rd_vld=%b ram_rd_addr=%h, required 0 00", ram_rd_vld, ram_rd_addr);
    end
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (cmd_rdy !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: cmd_rdy=%b busy=%b, required 1 0", cmd_rdy, busy);
    end
  endtask

  task automatic test_basic();
    int t, first_rd = -1, last_rd = -1, n_rd = 0, first_vld = -1, n_done = 0, done_c = -1, nb = 0;
    logic rdy_after = 1'b0;
    logic [SW-1:0] got [4];
    logic [SW-1:0] want [4] = '{16'hFFF0, 16'hFFFF, 16'hFFFF, 16'h0FFF};
    sync();
    out_rdy = 1'b1;
    send_cmd(8'h10, 3, 8'h01, 4, 11, t);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ram_rd_vld) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        n_rd++;
      end
      if (out_vld && first_vld < 0) first_vld = cyc;
      if (out_vld && out_rdy && nb < 4) begin
        got[nb] = out_strb;
        nb++;
      end
      if (done_c >= 0 && cyc == done_c + 1) rdy_after = cmd_rdy;
      if (done) begin
        n_done++;
        done_c = cyc;
      end
    end
    n_chk++;
    if (first_rd != t + 1 || n_rd != 4 || last_rd != first_rd + 3) begin
      n_fail++;
      $display("FAIL basic_reads: first=%0d count=%0d last=%0d, required first=%0d count=4 consecutive", first_rd, n_rd, last_rd, t + 1);
    end
    n_chk++;
    if (first_vld != t + 2 + RAM_LAT) begin
      n_fail++;
      $display("FAIL basic_latency: first out_vld cycle %0d, required %0d", first_vld, t + 2 + RAM_LAT);
    end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (k >= nb || got[k] !== want[k]) begin
        n_fail++;
        $display("FAIL basic_strb%0d: got %h (beats seen %0d), required %h", k, got[k], nb, want[k]);
      end
    end
    n_chk++;
    if (n_done != 1 || rdy_after !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done pulses=%0d cmd_rdy_after=%b busy=%b, required 1 1 0", n_done, rdy_after, busy);
    end
    wait_idle();
  endtask

  task automatic test_neg_stride();
    int t, n = 0;
    logic [AW-1:0] got [3];
    logic [AW-1:0] want [3] = '{8'h01, 8'h00, 8'hFF};
    sync();
    out_rdy = 1'b1;
    send_cmd(8'h01, 2, 8'hFF, 0, 15, t);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ram_rd_vld && n < 3) begin
        got[n] = ram_rd_addr;
        n++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (k >= n || got[k] !== want[k]) begin
        n_fail++;
        $display("FAIL neg_stride_addr%0d: got %h (reads %0d), required %h", k, got[k], n, want[k]);
      end
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int t, n_rd = 0, unstable = 0, nb = 0;
    logic have = 1'b0;
    logic [DATA_W-1:0] hold_d = '0;
    logic [SW-1:0] hold_s = '0;
    sync();
    out_rdy = 1'b0;
    send_cmd(8'h40, 15, 8'h01, 3, 12, t);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_rd_vld) n_rd++;
      if (out_vld) begin
        if (!have) begin
          hold_d = out_data;
          hold_s = out_strb;
          have = 1'b1;
        end else if (out_data !== hold_d || out_strb !== hold_s) unstable++;
      end
    end
    n_chk++;
    if (n_rd != DEPTH) begin
      n_fail++;
      $display("FAIL bp_reads: %0d reads while stalled, required %0d", n_rd, DEPTH);
    end
    n_chk++;
    if (!have || unstable != 0) begin
      n_fail++;
      $display("FAIL bp_hold: out_vld seen=%b unstable cycles=%0d, required 1 0", have, unstable);
    end
    sync();
    out_rdy = 1'b1;
    for (int i = 0; i < 200 && busy; i++) begin
      @(negedge clk);
      if (out_vld && out_rdy) nb++;
    end
    n_chk++;
    if (nb != 16 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_beats: %0d beats with %0d pending, required 16 beats 0 pending", nb, exp_q.size());
    end
    wait_idle();
  endtask

  task automatic test_single(input logic [AW-1:0] sa, input int sb, input int eb, input logic [SW-1:0] want);
    int t, nb = 0;
    logic [SW-1:0] s = '0;
    logic l = 1'b0, d = 1'b0;
    sync();
    out_rdy = 1'b1;
    send_cmd(sa, 0, 8'h01, sb, eb, t);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        s = out_strb;
        l = out_last;
        d = done;
        nb++;
      end
    end
    n_chk++;
    if (nb != 1 || s !== want || l !== 1'b1 || d !== 1'b1) begin
      n_fail++;
      $display("FAIL single_%0d_%0d: beats=%0d strb=%h last=%b done=%b, required 1 %h 1 1", sb, eb, nb, s, l, d, want);
    end
    wait_idle();
  endtask

  task automatic test_flush();
    int t, f = -1, bad = 0, nb = 0;
    logic [DATA_W-1:0] first_d = '0;
    sync();
    out_rdy = 1'b1;
    send_cmd(8'h80, 7, 8'h01, 0, 15, t);
    for (int i = 0; i < 20 && f < 0; i++) begin
      @(negedge clk);
      if (ram_rd_vld) f = cyc;
    end
    @(posedge clk);
    sync();
    flush = 1'b1;
    sync();
    flush = 1'b0;
    exp_q.delete();
    addr_exp_q.delete();
    @(negedge clk);
    n_chk++;
    if (f < 0 || out_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: first_read=%0d out_vld=%b busy=%b done=%b, required read seen 0 0 0", f, out_vld, busy, done);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_vld || done || busy) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL flush_late: %0d cycles with activity after flush, required 0", bad);
    end
    send_cmd(8'h90, 1, 8'h01, 0, 15, t);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_vld && out_rdy) begin
        if (nb == 0) first_d = out_data;
        nb++;
      end
    end
    n_chk++;
    if (nb != 2 || first_d !== row_data(8'h90)) begin
      n_fail++;
      $display("FAIL flush_next: beats=%0d first=%h, required 2 %h", nb, first_d, row_data(8'h90));
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    sync();
    out_rdy = 1'b1;
    send_cmd(8'h30, 3, 8'h01, 0, 15, t1);
    send_cmd(8'h50, 2, 8'h03, 1, 14, t2);
    n_chk++;
    if (last_done_cyc != t2 - 1) begin
      n_fail++;
      $display("FAIL b2b_accept: accepted cycle %0d with done at %0d, required done+1", t2, last_done_cyc);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_stride();
    test_backpressure();
    test_single(8'h22, 2, 5, 16'h003C);
    test_single(8'h23, 9, 3, 16'h0000);
    test_flush();
    test_back_to_back();
    n_chk++;
    if (exp_q.size() != 0 || addr_exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: %0d beats and %0d reads outstanding, required 0 0", exp_q.size(), addr_exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end
endmodule
